// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: data-memory req/ack access and MEM/WB pipeline register
module mem_access #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RSTD_WIDTH = 5
) (
  input  logic                  clk_87,
  input  logic                  rst_87,
  input  logic                  valid_in_87,
  input  logic                  reg_write_in_87,
  input  logic                  mem_2_reg_in_87,
  input  logic                  mem_read_in_87,
  input  logic                  mem_write_in_87,
  input  logic [ADDR_WIDTH-1:0] alu_result_in_87,
  input  logic [DATA_WIDTH-1:0] store_data_in_87,
  input  logic [RSTD_WIDTH-1:0] wb_reg_in_87,
  output logic                  stall_out_87,
  output logic                  dmem_req_87,
  output logic                  dmem_we_87,
  output logic [ADDR_WIDTH-1:0] dmem_addr_87,
  output logic [DATA_WIDTH-1:0] dmem_wdata_87,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_87,
  input  logic                  dmem_ack_87,
  output logic                  reg_write_out_87,
  output logic                  mem_2_reg_out_87,
  output logic [DATA_WIDTH-1:0] mem_data_out_87,
  output logic [ADDR_WIDTH-1:0] mem_addr_out_87,
  output logic [RSTD_WIDTH-1:0] wb_reg_out_87,
  output logic                  align_err_87
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  req_q, req_d;

  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic                  hold_we_q, hold_we_d;
  logic                  hold_rw_q, hold_rw_d;
  logic                  hold_m2r_q, hold_m2r_d;
  logic [RSTD_WIDTH-1:0] hold_wb_q, hold_wb_d;

  logic                  rw_q, rw_d;
  logic                  m2r_q, m2r_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [RSTD_WIDTH-1:0] wb_q, wb_d;
  logic                  err_q, err_d;

  logic accept;
  logic is_mem;
  logic illegal;

  assign accept  = valid_in_87 && (state_q == IDLE);
  assign is_mem  = mem_read_in_87 || mem_write_in_87;
  // Only memory ops can be illegal; ALU results are free to be unaligned.
  assign illegal = is_mem && ((alu_result_in_87[1:0] != 2'b00) ||
                              (mem_read_in_87 && mem_write_in_87));

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_we_d    = hold_we_q;
    hold_rw_d    = hold_rw_q;
    hold_m2r_d   = hold_m2r_q;
    hold_wb_d    = hold_wb_q;
    rw_d         = 1'b0;
    m2r_d        = m2r_q;
    data_d       = data_q;
    maddr_d      = maddr_q;
    wb_d         = wb_q;
    err_d        = 1'b0;

    if (state_q == WAIT) begin
      if (dmem_ack_87) begin
        state_d = IDLE;
        req_d   = 1'b0;
        rw_d    = hold_rw_q & ~hold_we_q;
        m2r_d   = hold_m2r_q;
        maddr_d = hold_addr_q;
        wb_d    = hold_wb_q;
        if (!hold_we_q) begin
          data_d = dmem_rdata_87;
        end
      end
    end else if (accept) begin
      if (!is_mem) begin
        rw_d    = reg_write_in_87;
        m2r_d   = mem_2_reg_in_87;
        maddr_d = alu_result_in_87;
        wb_d    = wb_reg_in_87;
      end else if (illegal) begin
        err_d = 1'b1;
      end else begin
        state_d      = WAIT;
        req_d        = 1'b1;
        hold_addr_d  = alu_result_in_87;
        hold_wdata_d = store_data_in_87;
        hold_we_d    = mem_write_in_87;
        hold_rw_d    = reg_write_in_87;
        hold_m2r_d   = mem_2_reg_in_87;
        hold_wb_d    = wb_reg_in_87;
      end
    end
  end

  always_ff @(posedge clk_87 or negedge rst_87) begin
    if (!rst_87) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_we_q    <= 1'b0;
      hold_rw_q    <= 1'b0;
      hold_m2r_q   <= 1'b0;
      hold_wb_q    <= '0;
      rw_q         <= 1'b0;
      m2r_q        <= 1'b0;
      data_q       <= '0;
      maddr_q      <= '0;
      wb_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_we_q    <= hold_we_d;
      hold_rw_q    <= hold_rw_d;
      hold_m2r_q   <= hold_m2r_d;
      hold_wb_q    <= hold_wb_d;
      rw_q         <= rw_d;
      m2r_q        <= m2r_d;
      data_q       <= data_d;
      maddr_q      <= maddr_d;
      wb_q         <= wb_d;
      err_q        <= err_d;
    end
  end

  assign stall_out_87     = (state_q == WAIT);
  assign dmem_req_87      = req_q;
  assign dmem_we_87       = hold_we_q;
  assign dmem_addr_87     = {hold_addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wdata_87    = hold_wdata_q;
  assign reg_write_out_87 = rw_q;
  assign mem_2_reg_out_87 = m2r_q;
  assign mem_data_out_87  = data_q;
  assign mem_addr_out_87  = maddr_q;
  assign wb_reg_out_87    = wb_q;
  assign align_err_87     = err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access with a transaction-level model
module tb_mem_access;

  logic        clk_87 = 1'b0;
  logic        rst_87 = 1'b1;
  logic        valid_in_87 = 1'b0;
  logic        reg_write_in_87 = 1'b0;
  logic        mem_2_reg_in_87 = 1'b0;
  logic        mem_read_in_87 = 1'b0;
  logic        mem_write_in_87 = 1'b0;
  logic [31:0] alu_result_in_87 = '0;
  logic [31:0] store_data_in_87 = '0;
  logic [4:0]  wb_reg_in_87 = '0;
  logic        stall_out_87;
  logic        dmem_req_87;
  logic        dmem_we_87;
  logic [31:0] dmem_addr_87;
  logic [31:0] dmem_wdata_87;
  logic [31:0] dmem_rdata_87 = '0;
  logic        dmem_ack_87;
  logic        reg_write_out_87;
  logic        mem_2_reg_out_87;
  logic [31:0] mem_data_out_87;
  logic [31:0] mem_addr_out_87;
  logic [4:0]  wb_reg_out_87;
  logic        align_err_87;

  int checks = 0;
  int errors = 0;

  mem_access dut (
    .clk_87(clk_87), .rst_87(rst_87), .valid_in_87(valid_in_87),
    .reg_write_in_87(reg_write_in_87), .mem_2_reg_in_87(mem_2_reg_in_87),
    .mem_read_in_87(mem_read_in_87), .mem_write_in_87(mem_write_in_87),
    .alu_result_in_87(alu_result_in_87), .store_data_in_87(store_data_in_87),
    .wb_reg_in_87(wb_reg_in_87), .stall_out_87(stall_out_87),
    .dmem_req_87(dmem_req_87), .dmem_we_87(dmem_we_87),
    .dmem_addr_87(dmem_addr_87), .dmem_wdata_87(dmem_wdata_87),
    .dmem_rdata_87(dmem_rdata_87), .dmem_ack_87(dmem_ack_87),
    .reg_write_out_87(reg_write_out_87), .mem_2_reg_out_87(mem_2_reg_out_87),
    .mem_data_out_87(mem_data_out_87), .mem_addr_out_87(mem_addr_out_87),
    .wb_reg_out_87(wb_reg_out_87), .align_err_87(align_err_87)
  );

  always #5 clk_87 = ~clk_87;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks after wait_n idle request cycles; stray_ack injects an unsolicited pulse.
  int          wait_n = 0;
  int          wcnt = 0;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] resp_data = '0;
  assign dmem_ack_87 = resp_ack | stray_ack;

  always @(negedge clk_87) begin
    #1;
    resp_ack = 1'b0;
    if (!rst_87 || !dmem_req_87) begin
      wcnt = 0;
    end else if (wcnt == wait_n) begin
      resp_ack = 1'b1;
      dmem_rdata_87 = resp_data;
      wcnt = 0;
    end else begin
      wcnt++;
    end
  end

  // Model: at most one outstanding access, kept as a queue of pending transactions.
  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wb;
  } acc_t;

  acc_t        pend[$];
  logic        m_rw = 0, m_m2r = 0, m_err = 0;
  logic [31:0] m_data = 0, m_addr = 0;
  logic [4:0]  m_wb = 0;

  always @(posedge clk_87 or negedge rst_87) begin
    acc_t p;
    if (!rst_87) begin
      pend.delete();
      m_rw = 0; m_m2r = 0; m_err = 0; m_data = 0; m_addr = 0; m_wb = 0;
    end else begin
      m_err = 0;
      m_rw  = 0;
      if (pend.size() != 0) begin
        if (dmem_ack_87) begin
          p = pend.pop_front();
          m_rw   = p.rw && !p.we;
          m_m2r  = p.m2r;
          m_addr = p.addr;
          m_wb   = p.wb;
          if (!p.we) m_data = dmem_rdata_87;
        end
      end else if (valid_in_87) begin
        if (!mem_read_in_87 && !mem_write_in_87) begin
          m_rw = reg_write_in_87; m_m2r = mem_2_reg_in_87;
          m_addr = alu_result_in_87; m_wb = wb_reg_in_87;
        end else if ((alu_result_in_87 % 4) != 0 || (mem_read_in_87 && mem_write_in_87)) begin
          m_err = 1;
        end else begin
          p = '{reg_write_in_87, mem_2_reg_in_87, mem_write_in_87,
                alu_result_in_87, store_data_in_87, wb_reg_in_87};
          pend.push_back(p);
        end
      end
    end
  end

  always @(negedge clk_87) begin
    chk("stall", {31'd0, stall_out_87}, {31'd0, pend.size() != 0});
    chk("req", {31'd0, dmem_req_87}, {31'd0, pend.size() != 0});
    chk("reg_write_out", {31'd0, reg_write_out_87}, {31'd0, m_rw});
    chk("mem_2_reg_out", {31'd0, mem_2_reg_out_87}, {31'd0, m_m2r});
    chk("mem_data_out", mem_data_out_87, m_data);
    chk("mem_addr_out", mem_addr_out_87, m_addr);
    chk("wb_reg_out", {27'd0, wb_reg_out_87}, {27'd0, m_wb});
    chk("align_err", {31'd0, align_err_87}, {31'd0, m_err});
    if (pend.size() != 0) begin
      chk("dmem_addr", dmem_addr_87, pend[0].addr);
      chk("dmem_wdata", dmem_wdata_87, pend[0].wdata);
      chk("dmem_we", {31'd0, dmem_we_87}, {31'd0, pend[0].we});
    end
  end

  task automatic step();
    @(negedge clk_87);
    #2;
  endtask

  // Present an instruction and hold it until the DUT accepts it.
  task automatic issue(input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wb);
    logic was_stall;
    int   n;
    valid_in_87 = 1; mem_read_in_87 = rd; mem_write_in_87 = wr;
    reg_write_in_87 = rw; mem_2_reg_in_87 = m2r;
    alu_result_in_87 = addr; store_data_in_87 = wdata; wb_reg_in_87 = wb;
    n = 0;
    do begin
      was_stall = stall_out_87;
      step();
      n++;
    end while (was_stall && n < 64);
    if (was_stall) chk("accept_timeout", 32'd1, 32'd0);
    valid_in_87 = 0; mem_read_in_87 = 0; mem_write_in_87 = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    #1 rst_87 = 0;
    step(); step();
    chk("rst_req", {31'd0, dmem_req_87}, 32'd0);
    chk("rst_stall", {31'd0, stall_out_87}, 32'd0);
    chk("rst_rw", {31'd0, reg_write_out_87}, 32'd0);
    chk("rst_addr", mem_addr_out_87, 32'd0);
    rst_87 = 1;
    step();

    issue(0, 0, 1, 0, 32'h10, 0, 5);
    chk("alu_rw", {31'd0, reg_write_out_87}, 32'd1);
    chk("alu_addr", mem_addr_out_87, 32'h10);
    chk("alu_wb", {27'd0, wb_reg_out_87}, 32'd5);
    chk("alu_stall", {31'd0, stall_out_87}, 32'd0);

    wait_n = 0; resp_data = 32'hDEADBEEF;
    issue(1, 0, 1, 1, 32'h100, 0, 7);
    chk("ld0_stall", {31'd0, stall_out_87}, 32'd1);
    chk("ld0_req_addr", dmem_addr_87, 32'h100);
    step();
    chk("ld0_stall_end", {31'd0, stall_out_87}, 32'd0);
    chk("ld0_data", mem_data_out_87, 32'hDEADBEEF);
    chk("ld0_m2r", {31'd0, mem_2_reg_out_87}, 32'd1);
    chk("ld0_rw", {31'd0, reg_write_out_87}, 32'd1);

    wait_n = 3;
    issue(0, 1, 1, 0, 32'h200, 32'h12345678, 9);
    n = 0;
    while (stall_out_87 && n < 20) begin
      chk("st_we", {31'd0, dmem_we_87}, 32'd1);
      chk("st_wdata", dmem_wdata_87, 32'h12345678);
      chk("st_rw_wait", {31'd0, reg_write_out_87}, 32'd0);
      n++;
      step();
    end
    chk("st_stall_cycles", n, 32'd4);
    chk("st_rw_done", {31'd0, reg_write_out_87}, 32'd0);
    chk("st_addr_done", mem_addr_out_87, 32'h200);

    issue(1, 0, 1, 1, 32'h102, 0, 3);
    chk("mis_err", {31'd0, align_err_87}, 32'd1);
    chk("mis_req", {31'd0, dmem_req_87}, 32'd0);
    chk("mis_rw", {31'd0, reg_write_out_87}, 32'd0);
    issue(0, 0, 1, 0, 32'h44, 0, 4);
    chk("mis_err_pulse", {31'd0, align_err_87}, 32'd0);
    chk("mis_next_addr", mem_addr_out_87, 32'h44);
    issue(1, 1, 1, 1, 32'h300, 0, 2);
    chk("rdwr_err", {31'd0, align_err_87}, 32'd1);

    stray_ack = 1; step(); stray_ack = 0;
    chk("stray_stall", {31'd0, stall_out_87}, 32'd0);
    step();

    wait_n = 5; resp_data = 32'h11111111;
    issue(1, 0, 1, 1, 32'h400, 0, 12);
    step(); step();
    chk("rstw_req_before", {31'd0, dmem_req_87}, 32'd1);
    rst_87 = 0;
    #1;
    chk("rstw_req", {31'd0, dmem_req_87}, 32'd0);
    chk("rstw_stall", {31'd0, stall_out_87}, 32'd0);
    chk("rstw_data", mem_data_out_87, 32'd0);
    chk("rstw_wb", {27'd0, wb_reg_out_87}, 32'd0);
    step();
    rst_87 = 1;
    wait_n = 1; resp_data = 32'hCAFEF00D;
    issue(1, 0, 1, 1, 32'h404, 0, 6);
    step(); step();
    chk("post_rst_data", mem_data_out_87, 32'hCAFEF00D);
    chk("post_rst_rw", {31'd0, reg_write_out_87}, 32'd1);

    wait_n = 2; resp_data = 32'h0BADF00D;
    issue(1, 0, 1, 1, 32'h500, 0, 8);
    valid_in_87 = 1; reg_write_in_87 = 1; mem_2_reg_in_87 = 0;
    alu_result_in_87 = 32'h600; wb_reg_in_87 = 10;
    step(); step();
    chk("b2b_stall_ack", {31'd0, stall_out_87}, 32'd1);
    step();
    chk("b2b_ld_data", mem_data_out_87, 32'h0BADF00D);
    chk("b2b_ld_wb", {27'd0, wb_reg_out_87}, 32'd8);
    chk("b2b_ld_rw", {31'd0, reg_write_out_87}, 32'd1);
    step();
    valid_in_87 = 0;
    chk("b2b_alu_addr", mem_addr_out_87, 32'h600);
    chk("b2b_alu_wb", {27'd0, wb_reg_out_87}, 32'd10);
    chk("b2b_alu_m2r", {31'd0, mem_2_reg_out_87}, 32'd0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage MIPS pipeline. It sits between the EX/MEM register and write_back, and owns the MEM/WB pipeline register.
- It issues loads and stores to a variable-latency data memory over a req/ack handshake, and stalls upstream while an access is outstanding.
- Its registered outputs drive write_back's reg_write, mem_2_reg, mem_data, mem_addr and wb_reg inputs.

Parameters:
- DATA_WIDTH, 32, data word width (matches `DATA_WIDTH).
- ADDR_WIDTH, 32, byte address width (matches `ADDR_WIDTH).
- RSTD_WIDTH, 5, register-specifier width (matches `FIELD_WIDTH_RSTD).

Ports:
- clk_87  in  1  pipeline clock; all state on posedge.
- rst_87  in  1  asynchronous, active-low reset.
- valid_in_87  in  1  EX/MEM holds a valid instruction.
- reg_write_in_87  in  1  instruction writes the register file.
- mem_2_reg_in_87  in  1  write-back source is memory data.
- mem_read_in_87  in  1  load.
- mem_write_in_87  in  1  store.
- alu_result_in_87  in  ADDR_WIDTH  effective address / ALU result.
- store_data_in_87  in  DATA_WIDTH  rt value for stores.
- wb_reg_in_87  in  RSTD_WIDTH  destination register.
- stall_out_87  out  1  upstream must hold EX/MEM contents.
- dmem_req_87  out  1  memory request.
- dmem_we_87  out  1  1 = store, 0 = load.
- dmem_addr_87  out  ADDR_WIDTH  word-aligned request address.
- dmem_wdata_87  out  DATA_WIDTH  store data.
- dmem_rdata_87  in  DATA_WIDTH  load data, valid with ack.
- dmem_ack_87  in  1  one-cycle completion pulse.
- reg_write_out_87  out  1  MEM/WB reg_write.
- mem_2_reg_out_87  out  1  MEM/WB mem_2_reg.
- mem_data_out_87  out  DATA_WIDTH  MEM/WB load data.
- mem_addr_out_87  out  ADDR_WIDTH  MEM/WB ALU result.
- wb_reg_out_87  out  RSTD_WIDTH  MEM/WB destination register.
- align_err_87  out  1  one-cycle pulse: misaligned or illegal access.

Behaviour:
- Reset: all outputs are 0 and the FSM is IDLE. Assertion takes effect immediately, without waiting for a clock; this also applies mid-access, so dmem_req drops at once. No response is expected for an aborted request.
- FSM has two states, IDLE and WAIT. stall_out_87 = (state == WAIT), combinational.
- An instruction is accepted when valid_in_87 = 1 and state = IDLE.
- Non-memory instruction accepted: on the next edge, MEM/WB loads reg_write, mem_2_reg, alu_result→mem_addr_out and wb_reg. mem_data_out is held. Latency 1.
- Memory op accepted with alu_result[1:0] == 00 and not both read and write:
  - Capture addr, wdata, we and the wb fields into hold registers; go to WAIT.
  - dmem_req_87 is registered: high from the first WAIT cycle until the cycle ack is sampled.
  - dmem_addr/wdata/we are driven from the hold registers and stay stable while req is high.
  - While in WAIT, MEM/WB carries a bubble: reg_write_out = 0, other fields held.
- dmem_ack_87 sampled high in WAIT: on that edge, MEM/WB loads the hold fields.
  - Load: mem_data_out = dmem_rdata_87.
  - reg_write_out = hold reg_write & ~we, so a store never writes the register file.
  - FSM returns to IDLE; req drops.
- Minimum load-to-WB latency: accept at edge N, req visible after N, ack sampled at N+1, outputs valid after N+1. Every extra wait cycle adds 1.
- Misaligned address (alu_result[1:0] != 00), or read and write both set: no request is issued and the FSM stays IDLE. MEM/WB gets a bubble (reg_write_out = 0) and align_err_87 pulses for exactly 1 cycle.
- valid_in_87 = 0 in IDLE: bubble, reg_write_out = 0.
- dmem_ack_87 in IDLE is ignored, with no state change.
- Ack in the same cycle that valid_in_87 presents the next instruction: that instruction is not accepted because the FSM is still in WAIT. It is accepted on the following cycle.

Test Plan:
- ALU op: reg_write=1, mem_2_reg=0, addr=0x0000_0010, wb_reg=5 → next cycle reg_write_out=1, mem_addr_out=0x10, wb_reg_out=5, stall_out=0.
- Load with 0-cycle wait: addr=0x100, ack in the first req cycle, rdata=0xDEADBEEF → stall high for 1 cycle, then mem_data_out=0xDEADBEEF, mem_2_reg_out=1, reg_write_out=1.
- Store with 3 wait cycles: addr=0x200, data=0x1234_5678 → req held high for 4 cycles with stable we=1, addr=0x200, wdata=0x12345678. Stall lasts 4 cycles, reg_write_out=0 throughout and after completion.
- Misaligned load at addr=0x102 → dmem_req stays 0, align_err pulses 1 cycle, reg_write_out=0, and the next aligned op is accepted on the following cycle.
- Reset asserted mid-WAIT (2 cycles into a load) → dmem_req, stall_out and all MEM/WB outputs go 0 immediately. After release, a fresh load completes normally.
- Back-to-back: load followed by an ALU op held at the input → the ALU op is accepted the cycle after ack, and the MEM/WB outputs show the load result, then the ALU result, in consecutive cycles.
